// File: rtl/game2048_pkg.sv
// 2048 board move shared definitions: directions, cell width,
// FSM encoding and the (dir, line, pos) -> cell index map.
package game2048_pkg;

   localparam int CELL_W = 4;
   localparam logic [CELL_W-1:0] MAX_EXP = '1;

   localparam logic [1:0] DIR_LEFT  = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_UP    = 2'd2;
   localparam logic [1:0] DIR_DOWN  = 2'd3;

   typedef logic [2:0] state_t;

   localparam state_t ST_INIT  = 3'd0;
   localparam state_t ST_IDLE  = 3'd1;
   localparam state_t ST_LINE0 = 3'd2;
   localparam state_t ST_LINE1 = 3'd3;
   localparam state_t ST_LINE2 = 3'd4;
   localparam state_t ST_LINE3 = 3'd5;
   localparam state_t ST_SPAWN = 3'd6;
   localparam state_t ST_CHECK = 3'd7;

   // pos 0 is the edge the tiles slide toward; result is {row, col}
   function automatic logic [3:0] cell_idx(
      input logic [1:0] dir,
      input logic [1:0] ln,
      input logic [1:0] pos
   );
      logic [1:0] rp;
      logic [3:0] idx;
      rp = 2'd3 - pos;
      case (dir)
         DIR_LEFT:  idx = {ln, pos};
         DIR_RIGHT: idx = {ln, rp};
         DIR_UP:    idx = {pos, ln};
         default:   idx = {rp, ln};
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/line_merge4.sv
// Combinational slide/merge of one 4-cell line toward index 0.
// Ports: cells_in/cells_out (4 exponents), changed, score_inc (SCORE_EN).
module line_merge4
   import game2048_pkg::*;
(
   input  logic [3:0][CELL_W-1:0] cells_in,
   output logic [3:0][CELL_W-1:0] cells_out,
   output logic                   changed
`ifdef SCORE_EN
  ,output logic [19:0]            score_inc
`endif
);

   // extra zero slot so the pair compare at index 3 stays in range
   logic [4:0][CELL_W-1:0] c;
   logic [CELL_W-1:0]      e;
   logic [2:0]             k;
   logic [1:0]             j;
   logic                   skip;

   always_comb begin
      c = '0;
      k = '0;
      for (int i = 0; i < 4; i++) begin
         if (cells_in[i] != '0) begin
            c[k] = cells_in[i];
            k = k + 3'd1;
         end
      end
      cells_out = '0;
      e = '0;
      j = '0;
      skip = 1'b0;
`ifdef SCORE_EN
      score_inc = '0;
`endif
      for (int i = 0; i < 4; i++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (c[i] != '0) begin
            if (c[i] == c[i+1]) begin
               e = (c[i] == MAX_EXP) ? MAX_EXP : c[i] + 1'b1;
               cells_out[j] = e;
               skip = 1'b1;
`ifdef SCORE_EN
               score_inc = score_inc + (20'd1 << e);
`endif
            end else begin
               cells_out[j] = c[i];
            end
            j = j + 2'd1;
         end
      end
      changed = (cells_out != cells_in);
   end

endmodule

// File: rtl/board_move_ctrl.sv
// 2048 move sequencer: slide/merge 4 lines, spawn a tile, evaluate end state.
// Ports: clk, clr (sync reset), move_valid/move_dir in; busy, done, moved,
// board, game_over, win out; score out only when SCORE_EN is defined.
module board_move_ctrl
   import game2048_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          WIN_EXP   = 11
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               move_valid,
   input  logic [1:0]         move_dir,
   output logic               busy,
   output logic               done,
   output logic               moved,
   output logic [16*CELL_W-1:0] board,
   output logic               game_over,
   output logic               win
`ifdef SCORE_EN
  ,output logic [19:0]        score
`endif
);

   state_t                    st;
   logic [15:0][CELL_W-1:0]   board_q;
   logic [15:0]               lfsr;
   logic [1:0]                dir_q;
   logic                      changed;
   logic [3:0]                p;
   logic [3:0]                pcnt;
   logic                      last;
   logic                      go_q;
   logic                      win_q;

   logic [1:0]                ln;
   logic [3:0][CELL_W-1:0]    lin;
   logic [3:0][CELL_W-1:0]    lout;
   logic                      lchg;
   logic                      fb;
   logic                      sp_empty;
   logic [CELL_W-1:0]         sp_val;
   logic                      full;
   logic                      pair;
   logic                      win_now;
   logic                      go_now;

   assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   always_comb begin
      ln = 2'(st - ST_LINE0);
      lin = '0;
      for (int k = 0; k < 4; k++) begin
         lin[k] = board_q[cell_idx(dir_q, ln, 2'(k))];
      end
   end

`ifdef SCORE_EN
   logic [19:0] score_q;
   logic [19:0] sinc;
   logic [20:0] score_sum;

   assign score_sum = {1'b0, score_q} + {1'b0, sinc};
   assign score = score_q;

   line_merge4 u_merge (
      .cells_in  (lin),
      .cells_out (lout),
      .changed   (lchg),
      .score_inc (sinc)
   );
`else
   line_merge4 u_merge (
      .cells_in  (lin),
      .cells_out (lout),
      .changed   (lchg)
   );
`endif

   assign sp_empty = (board_q[p] == '0);
   assign sp_val = (lfsr[7:4] == 4'd0) ? CELL_W'(2) : CELL_W'(1);

   always_comb begin
      full = 1'b1;
      pair = 1'b0;
      win_now = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (board_q[i] == '0) full = 1'b0;
         if (board_q[i] >= CELL_W'(WIN_EXP)) win_now = 1'b1;
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (board_q[r*4+c] == board_q[r*4+c+1]) pair = 1'b1;
         end
      end
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (board_q[r*4+c] == board_q[r*4+c+4]) pair = 1'b1;
         end
      end
   end

   assign go_now = full & ~pair;

   always_ff @(posedge clk) begin
      if (clr) begin
         st      <= ST_INIT;
         board_q <= '0;
         lfsr    <= LFSR_SEED;
         dir_q   <= DIR_LEFT;
         changed <= 1'b0;
         p       <= '0;
         pcnt    <= '0;
         last    <= 1'b0;
         go_q    <= 1'b0;
         win_q   <= 1'b0;
`ifdef SCORE_EN
         score_q <= '0;
`endif
      end else begin
         lfsr <= {lfsr[14:0], fb};
         case (st)
            ST_INIT: begin
               p    <= lfsr[3:0];
               pcnt <= '0;
               last <= 1'b0;
               st   <= ST_SPAWN;
            end
            ST_IDLE: begin
               if (move_valid) begin
                  dir_q   <= move_dir;
                  changed <= 1'b0;
                  st      <= ST_LINE0;
               end
            end
            ST_LINE0, ST_LINE1, ST_LINE2, ST_LINE3: begin
               for (int k = 0; k < 4; k++) begin
                  board_q[cell_idx(dir_q, ln, 2'(k))] <= lout[k];
               end
               changed <= changed | lchg;
`ifdef SCORE_EN
               score_q <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
`endif
               if (st != ST_LINE3) begin
                  st <= st + 3'd1;
               end else if (changed | lchg) begin
                  p    <= lfsr[3:0];
                  pcnt <= '0;
                  last <= 1'b1;
                  st   <= ST_SPAWN;
               end else begin
                  st <= ST_CHECK;
               end
            end
            ST_SPAWN: begin
               if (sp_empty) board_q[p] <= sp_val;
               if (sp_empty || pcnt == 4'd15) begin
                  // init runs a second pass from a fresh probe point
                  if (last) begin
                     st <= ST_CHECK;
                  end else begin
                     p    <= lfsr[3:0];
                     pcnt <= '0;
                     last <= 1'b1;
                  end
               end else begin
                  p    <= p + 4'd1;
                  pcnt <= pcnt + 4'd1;
               end
            end
            ST_CHECK: begin
               go_q  <= go_now;
               win_q <= win_q | win_now;
               st    <= ST_IDLE;
            end
            default: st <= ST_INIT;
         endcase
      end
   end

   assign busy      = (st != ST_IDLE);
   assign done      = (st == ST_CHECK);
   assign moved     = done & changed;
   assign board     = board_q;
   assign game_over = done ? go_now : go_q;
   assign win       = win_q | (done & win_now);

endmodule

// File: doc/board_move_ctrl.md
Name: board_move_ctrl

Overview:
- Sequences one 2048 move over the 4x4 tile board.
- Each move does: per-line slide/merge in the chosen direction, random new-tile spawn, then game-over/win evaluation.
- Owns the board register and feeds the VGA renderer through a flat board bus.
- Sits between button debounce/edge logic and the VGA draw path.

Parameters:
- CELL_W, 4, tile exponent width (0 = empty, n = tile value 2^n).
- LFSR_SEED, 16'hACE1, reset seed of the 16-bit Fibonacci LFSR with taps 16,14,13,11. Must be nonzero.
- WIN_EXP, 11, exponent that asserts win (tile 2048).

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous active-high reset.
- move_valid  in  1  move request, sampled only while busy=0.
- move_dir  in  2  direction: 0 left, 1 right, 2 up, 3 down.
- busy  out  1  high from request accept until the done cycle (inclusive).
- done  out  1  one-cycle pulse when a move (or the reset init) completes.
- moved  out  1  valid with done: board changed during the slide/merge.
- board  out  16*CELL_W  cell i = row*4+col, at bits [CELL_W*i +: CELL_W].
- game_over  out  1  no empty cell and no equal orthogonal neighbours.
- win  out  1  sticky; any cell >= WIN_EXP.

Behaviour:
- Reset (clr=1 at a clk edge, any state, including mid-move):
  - board=0, busy=1, done=0, moved=0, game_over=0, win=0, LFSR=LFSR_SEED.
  - Any in-flight move is discarded.
  - State goes to INIT.
- States: INIT -> SPAWN(x2) -> CHECK -> IDLE; IDLE -> LINE0..LINE3 -> SPAWN -> CHECK -> IDLE.
- The LFSR advances every cycle.
- IDLE:
  - busy=0.
  - move_valid=1 latches move_dir, clears the changed flag and goes to LINE0.
  - move_valid while busy=1 is ignored; no queueing.
- LINEk (one cycle each):
  - Gather 4 cells ordered from the edge the tiles move toward:
    - left: row k, cols 0..3; right: row k, cols 3..0.
    - up: col k, rows 0..3; down: col k, rows 3..0.
  - Merge the line (sub-module) and write back the same cycle.
  - Set changed if any written cell differs from its old value.
- Merge rule:
  - Compress nonzero values toward index 0.
  - Scan from index 0: equal adjacent pair -> one cell of value+1; each tile merges at most once.
  - Exponent saturates at 2^CELL_W-1.
  - Examples: [1,1,1,1]->[2,2,0,0]; [1,0,1,2]->[2,2,0,0]; [2,2,2,0]->[3,2,0,0].
- SPAWN:
  - Entered after LINE3 only if changed=1; otherwise go straight to CHECK with moved=0.
  - Probe index p=LFSR[3:0] on entry, then p+1 mod 16 each cycle, at most 16 cycles.
  - First empty cell gets exponent 2 if LFSR[7:4]==0, else 1.
  - No empty cell found: nothing written.
  - INIT performs two SPAWN passes; the second must pick a different cell.
- CHECK (one cycle):
  - Evaluate game_over and win on the final board.
  - Pulse done and set moved=changed.
  - game_over and win hold until the next CHECK or reset.
- Latency: accept -> done is 6 cycles (4 lines + 1 spawn probe + check) when the first probe hits; worst case 21 cycles.
- Simultaneous move_valid and clr: clr wins.

Optional Feature:
- SCORE_EN defined:
  - Adds output score [19:0], reset 0.
  - Each merge producing exponent e adds 2^e during its LINE cycle.
  - Saturates at 20'hFFFFF.
- SCORE_EN undefined: no score port and no accumulator logic.

Decomposition:
- Package game2048_pkg holds:
  - direction constants DIR_LEFT/RIGHT/UP/DOWN;
  - CELL_W;
  - the state enum;
  - a function mapping (dir, line, pos) to a cell index.
- Sub-module line_merge4: combinational, 4 cells in -> 4 cells out, plus a changed flag and (under SCORE_EN) a score increment.

Test Plan:
- Reset then idle:
  - Expect exactly two nonzero cells, each of value 1 or 2.
  - done pulses once; game_over=0.
- Force row 0 = [1,1,1,1], other rows empty, move left:
  - Row 0 becomes [2,2,0,0] before spawn; moved=1.
  - With SCORE_EN, score +8.
- Board where a left move changes nothing (e.g. row0 [1,2,0,0], rest 0):
  - moved=0, board unchanged, no spawn.
  - done arrives 5 cycles after accept.
- Full checkerboard of 1/2 with no equal neighbours:
  - Any move gives moved=0 and game_over=1.
- Cells 0 and 1 = 10, move left:
  - Cell 0 = 11, win=1.
  - win stays 1 across a later non-winning move.
- Assert clr during LINE2 of a move:
  - Next cycle board=0, state INIT, done=0.
  - move_valid applied during busy is ignored.
